regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with a per-register scoreboard, for the E10 RV32 core's decode/writeback boundary. It provides NRD synchronous read ports with write-through bypass and one write port. A reservation port marks a destination register busy when an instruction issues, and the writeback clears it. Decode uses the per-port busy flags to stall on RAW hazards. It generalises the current fixed 2-read, 32x32 register file.

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers; power of two, ≥2; AW = $clog2(NREGS)
- NRD, 2, number of read ports, 1..4
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  reset, **synchronous, active-low**
- rd_en_i  in  NRD  per-port read enable
- rd_addr_i  in  NRD*AW  read addresses; port p occupies [p*AW +: AW]
- rd_data_o  out  NRD*XLEN  registered read data; port p occupies [p*XLEN +: XLEN]
- rd_busy_o  out  NRD  registered busy flag of the register read on port p
- wr_en_i  in  1  writeback enable
- wr_addr_i  in  AW  writeback destination
- wr_data_i  in  XLEN  writeback data
- rsv_en_i  in  1  issue reservation: mark rsv_addr_i busy
- rsv_addr_i  in  AW  register being reserved
- flush_i  in  1  clear all busy bits (pipeline flush); register data is kept
- busy_o  out  NREGS  current scoreboard vector, bit i = register i busy

## Operation
- Register 0 is hardwired zero.
  - Writes to address 0 are ignored.
  - Reservations of address 0 are ignored.
  - busy_o[0] is always 0.
  - A read of address 0 returns 0 with busy 0.
- Write: when wr_en_i=1 and wr_addr_i≠0, regs[wr_addr_i] ← wr_data_i at the edge. The write also clears busy[wr_addr_i], unless the same register is reserved in that cycle.
- Reserve: when rsv_en_i=1 and rsv_addr_i≠0, busy[rsv_addr_i] ← 1.
- Busy-bit update priority, highest first:
  1. rst_ni=0
  2. flush_i=1: all busy bits cleared; any same-cycle rsv_en_i is dropped; a same-cycle write still updates data.
  3. rsv_en_i sets the bit.
  4. wr_en_i clears the bit.
- Reserve and write to the same address in one cycle: data is written and busy stays 1, because a new producer has been issued.
- A write to a non-busy register is legal: data is updated and busy is unchanged.
- Read, port p with rd_en_i[p]=1, captured at the edge:
  - rd_data_o[p] ← regs[addr]. If wr_en_i=1 and wr_addr_i=addr≠0 in the same cycle, it takes wr_data_i instead (write-through bypass).
  - rd_busy_o[p] ← busy[addr] evaluated *after* this edge's update. A read that coincides with the clearing writeback therefore reports 0; one that coincides with a reservation reports 1.
- rd_en_i[p]=0: rd_data_o[p] and rd_busy_o[p] hold their values.
- Reset (rst_ni=0 at an edge):
  - all regs ← 0
  - all busy ← 0
  - rd_data_o ← 0
  - rd_busy_o ← 0
  - the write, reserve and flush inputs are ignored in that cycle.

## Timing
- Read latency is 1 cycle: address presented in cycle N, data and busy valid after edge N+1, stable through cycle N+1.
- Write-to-read latency is 0 extra cycles, via the bypass. busy_o reflects the write from the cycle after the write edge.
- busy_o is a direct flop output with no combinational path from the inputs.
- No handshake: every enabled operation completes in its cycle, and the block never stalls.
- Reset mid-operation: an asserted rst_ni overrides all in-flight operations at that edge. The first operation accepted is on the edge after rst_ni returns to 1.

## Structure
- XLEN/NREGS defaults and the x0 index constant go in the shared RV32 include alongside the opcode definitions. The core top passes them down.
- Storage array and scoreboard live in regfile_sb.
- One sub-module, regfile_rd_port, is instantiated NRD times via generate. It holds the port's address mux, bypass compare, zero-register check and the rd_data/rd_busy output flops.

## Test plan
- Reset: drive rst_ni=0 for 2 cycles with random writes and reservations → all rd_data_o=0, busy_o=0. After release, reading x5 returns 0.
- Bypass: write x7=0xDEADBEEF while port 0 reads x7 in the same cycle → next cycle rd_data_o[0]=0xDEADBEEF. Port 1 reading x7 one cycle later also returns 0xDEADBEEF.
- Scoreboard: reserve x3 → busy_o[3]=1 next cycle. Read x3 → rd_busy_o=1. Write x3=0x12 → busy_o[3]=0. A read in the write cycle returns 0x12 with busy 0.
- Simultaneous reserve and write to x9 → data written, busy_o[9] remains 1. Reserve x9 together with flush_i=1 → busy_o=0.
- x0: write x0=0xFFFFFFFF and reserve x0 → reading x0 on all ports gives 0, busy 0, and busy_o[0]=0.
- Parameters: NREGS=16, NRD=3, XLEN=64 → three ports read distinct registers concurrently with correct 64-bit data.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared RV32 register-file constants: default widths and the hardwired-zero index.
package regfile_sb_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int X0        = 0;
endpackage

// File: rtl/regfile_rd_port.sv
// One synchronous read port: address mux, write-through bypass, x0 check, output flops.
module regfile_rd_port
  import regfile_sb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        en,
  input  logic [AW-1:0]               addr,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
  input  logic [NREGS-1:0]            busy_nxt,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [XLEN-1:0]             wr_data,
  output logic [XLEN-1:0]             rd_data,
  output logic                        rd_busy
);
  logic [XLEN-1:0] data_sel;
  logic            busy_sel;
  logic            is_x0;

  assign is_x0 = (addr == AW'(X0));

  always_comb begin
    data_sel = regs[addr];
    if (wr_en && (wr_addr == addr)) data_sel = wr_data;
    if (is_x0) data_sel = '0;
    // busy is sampled post-update so a coinciding writeback/reservation is visible
    busy_sel = busy_nxt[addr] & ~is_x0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data <= '0;
      rd_busy <= 1'b0;
    end else if (en) begin
      rd_data <= data_sel;
      rd_busy <= busy_sel;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Integer register file with per-register scoreboard, NRD bypassed read ports, one write port.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NRD-1:0]       rd_en_i,
  input  logic [NRD*AW-1:0]    rd_addr_i,
  output logic [NRD*XLEN-1:0]  rd_data_o,
  output logic [NRD-1:0]       rd_busy_o,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [XLEN-1:0]      wr_data_i,
  input  logic                 rsv_en_i,
  input  logic [AW-1:0]        rsv_addr_i,
  input  logic                 flush_i,
  output logic [NREGS-1:0]     busy_o
);
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;
  logic [NREGS-1:0]           busy_nxt;
  logic                       wr_ok;

  assign wr_ok = wr_en_i && (wr_addr_i != AW'(X0));

  // Reservation beats writeback: a same-cycle reserve means a newer producer is in flight.
  always_comb begin
    busy_nxt = busy;
    if (flush_i) begin
      busy_nxt = '0;
    end else begin
      if (wr_en_i)  busy_nxt[wr_addr_i]  = 1'b0;
      if (rsv_en_i) busy_nxt[rsv_addr_i] = 1'b1;
    end
    busy_nxt[X0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      regs <= '0;
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      if (wr_ok) regs[wr_addr_i] <= wr_data_i;
    end
  end

  assign busy_o = busy;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_rd_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_port (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en       (rd_en_i[p]),
      .addr     (rd_addr_i[p*AW +: AW]),
      .regs     (regs),
      .busy_nxt (busy_nxt),
      .wr_en    (wr_ok),
      .wr_addr  (wr_addr_i),
      .wr_data  (wr_data_i),
      .rd_data  (rd_data_o[p*XLEN +: XLEN]),
      .rd_busy  (rd_busy_o[p])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 32x32/2-port instance and a 16x64/3-port instance.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance
  logic [1:0]   rd_en_a;
  logic [9:0]   rd_addr_a;
  logic [63:0]  rd_data_a;
  logic [1:0]   rd_busy_a;
  logic         wr_en_a, rsv_en_a, flush_a;
  logic [4:0]   wr_addr_a, rsv_addr_a;
  logic [31:0]  wr_data_a;
  logic [31:0]  busy_a;

  regfile_sb dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_en_i(rd_en_a), .rd_addr_i(rd_addr_a), .rd_data_o(rd_data_a), .rd_busy_o(rd_busy_a),
    .wr_en_i(wr_en_a), .wr_addr_i(wr_addr_a), .wr_data_i(wr_data_a),
    .rsv_en_i(rsv_en_a), .rsv_addr_i(rsv_addr_a), .flush_i(flush_a), .busy_o(busy_a)
  );

  // NREGS=16, NRD=3, XLEN=64 instance
  logic [2:0]   rd_en_b;
  logic [11:0]  rd_addr_b;
  logic [191:0] rd_data_b;
  logic [2:0]   rd_busy_b;
  logic         wr_en_b, rsv_en_b, flush_b;
  logic [3:0]   wr_addr_b, rsv_addr_b;
  logic [63:0]  wr_data_b;
  logic [15:0]  busy_b;

  regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_en_i(rd_en_b), .rd_addr_i(rd_addr_b), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .wr_en_i(wr_en_b), .wr_addr_i(wr_addr_b), .wr_data_i(wr_data_b),
    .rsv_en_i(rsv_en_b), .rsv_addr_i(rsv_addr_b), .flush_i(flush_b), .busy_o(busy_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    rd_en_a = '0; wr_en_a = 1'b0; rsv_en_a = 1'b0; flush_a = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_a();
    rd_addr_a = '0; wr_addr_a = '0; rsv_addr_a = '0; wr_data_a = '0;
    rd_en_b = '0; rd_addr_b = '0; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    rsv_en_b = 1'b0; rsv_addr_b = '0; flush_b = 1'b0;

    // reset with random write/reserve traffic
    for (int i = 0; i < 2; i++) begin
      wr_en_a = 1'b1; wr_addr_a = 5'($urandom_range(1, 31)); wr_data_a = $urandom;
      rsv_en_a = 1'b1; rsv_addr_a = 5'($urandom_range(1, 31));
      rd_en_a = 2'b11; rd_addr_a = {wr_addr_a, wr_addr_a};
      tick();
    end
    check("rst_data", {32'h0, rd_data_a[63:0] == 64'h0 ? 32'h0 : 32'h1}, 64'h0);
    check("rst_rbusy", {62'h0, rd_busy_a}, 64'h0);
    check("rst_busy", {32'h0, busy_a}, 64'h0);
    check("rst_busy_b", {48'h0, busy_b}, 64'h0);

    rst_n = 1'b1; idle_a();
    rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd5};
    tick();
    check("post_rst_x5", {32'h0, rd_data_a[31:0]}, 64'h0);
    check("post_rst_x5_busy", {63'h0, rd_busy_a[0]}, 64'h0);

    // bypass: write x7 while port 0 reads it
    idle_a();
    wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'hDEADBEEF;
    rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd7};
    tick();
    check("bypass_p0", {32'h0, rd_data_a[31:0]}, 64'hDEADBEEF);
    idle_a();
    rd_en_a = 2'b10; rd_addr_a = {5'd7, 5'd0};
    tick();
    check("read_p1_x7", {32'h0, rd_data_a[63:32]}, 64'hDEADBEEF);
    check("hold_p0", {32'h0, rd_data_a[31:0]}, 64'hDEADBEEF);

    // scoreboard reserve / read / clearing writeback
    idle_a();
    rsv_en_a = 1'b1; rsv_addr_a = 5'd3;
    tick();
    check("rsv_x3", {32'h0, busy_a}, 64'h8);
    idle_a();
    rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd3};
    tick();
    check("rd_busy_x3", {63'h0, rd_busy_a[0]}, 64'h1);
    idle_a();
    wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'h12;
    rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd3};
    tick();
    check("wb_x3_data", {32'h0, rd_data_a[31:0]}, 64'h12);
    check("wb_x3_rbusy", {63'h0, rd_busy_a[0]}, 64'h0);
    check("wb_x3_busy", {32'h0, busy_a}, 64'h0);

    // read coinciding with a reservation sees busy
    idle_a();
    rsv_en_a = 1'b1; rsv_addr_a = 5'd4;
    rd_en_a = 2'b10; rd_addr_a = {5'd4, 5'd0};
    tick();
    check("rsv_rd_x4", {63'h0, rd_busy_a[1]}, 64'h1);
    check("rsv_x4_busy", {32'h0, busy_a}, 64'h10);

    // simultaneous reserve + write x9
    idle_a();
    rsv_en_a = 1'b1; rsv_addr_a = 5'd9;
    wr_en_a = 1'b1; wr_addr_a = 5'd9; wr_data_a = 32'h99;
    tick();
    check("rsv_wr_x9_busy", {32'h0, busy_a}, 64'h210);
    idle_a();
    rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd9};
    tick();
    check("rsv_wr_x9_data", {32'h0, rd_data_a[31:0]}, 64'h99);
    check("rsv_wr_x9_rbusy", {63'h0, rd_busy_a[0]}, 64'h1);

    // flush drops a same-cycle reservation, write still lands
    idle_a();
    flush_a = 1'b1;
    rsv_en_a = 1'b1; rsv_addr_a = 5'd9;
    wr_en_a = 1'b1; wr_addr_a = 5'd10; wr_data_a = 32'hAB;
    rd_en_a = 2'b10; rd_addr_a = {5'd10, 5'd0};
    tick();
    check("flush_busy", {32'h0, busy_a}, 64'h0);
    check("flush_wr_data", {32'h0, rd_data_a[63:32]}, 64'hAB);
    check("flush_rbusy", {63'h0, rd_busy_a[1]}, 64'h0);

    // x0 is hardwired
    idle_a();
    wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'hFFFFFFFF;
    rsv_en_a = 1'b1; rsv_addr_a = 5'd0;
    rd_en_a = 2'b11; rd_addr_a = {5'd0, 5'd0};
    tick();
    check("x0_data_byp", rd_data_a, 64'h0);
    check("x0_rbusy_byp", {62'h0, rd_busy_a}, 64'h0);
    idle_a();
    rd_en_a = 2'b11; rd_addr_a = {5'd0, 5'd0};
    tick();
    check("x0_data", rd_data_a, 64'h0);
    check("x0_rbusy", {62'h0, rd_busy_a}, 64'h0);
    check("x0_busy", {32'h0, busy_a}, 64'h0);

    // reset mid-operation clears data and scoreboard
    idle_a();
    rsv_en_a = 1'b1; rsv_addr_a = 5'd6;
    tick();
    check("pre_rst_busy", {32'h0, busy_a}, 64'h40);
    rst_n = 1'b0;
    wr_en_a = 1'b1; wr_addr_a = 5'd8; wr_data_a = 32'h55;
    rsv_en_a = 1'b1; rsv_addr_a = 5'd8;
    tick();
    check("mid_rst_busy", {32'h0, busy_a}, 64'h0);
    check("mid_rst_data", rd_data_a, 64'h0);
    rst_n = 1'b1; idle_a();
    rd_en_a = 2'b11; rd_addr_a = {5'd8, 5'd7};
    tick();
    check("mid_rst_x7", {32'h0, rd_data_a[31:0]}, 64'h0);
    check("mid_rst_x8", {32'h0, rd_data_a[63:32]}, 64'h0);

    // wide instance: three ports on distinct registers
    wr_en_b = 1'b1; wr_addr_b = 4'd1; wr_data_b = 64'h0123456789ABCDEF; tick();
    wr_addr_b = 4'd2; wr_data_b = 64'hFEDCBA9876543210; tick();
    wr_addr_b = 4'd15; wr_data_b = 64'hA5A5_5A5A_C3C3_3C3C;
    rd_en_b = 3'b111; rd_addr_b = {4'd15, 4'd2, 4'd1};
    tick();
    check("b_p0_x1", rd_data_b[63:0], 64'h0123456789ABCDEF);
    check("b_p1_x2", rd_data_b[127:64], 64'hFEDCBA9876543210);
    check("b_p2_x15_byp", rd_data_b[191:128], 64'hA5A5_5A5A_C3C3_3C3C);
    wr_en_b = 1'b0;
    rsv_en_b = 1'b1; rsv_addr_b = 4'd15;
    rd_addr_b = {4'd1, 4'd15, 4'd2};
    tick();
    check("b_p0_x2", rd_data_b[63:0], 64'hFEDCBA9876543210);
    check("b_p1_x15", rd_data_b[127:64], 64'hA5A5_5A5A_C3C3_3C3C);
    check("b_p2_x1", rd_data_b[191:128], 64'h0123456789ABCDEF);
    check("b_rbusy", {61'h0, rd_busy_b}, 64'h2);
    check("b_busy", {48'h0, busy_b}, 64'h8000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
